seg14_scroll_mux: RTL and testbench

Parametrised scanner for a multiplexed bank of 14-segment digits, driven from a writable message buffer instead of fixed text. Host logic writes raw 14-bit segment patterns into an internal buffer; the block scans digits one-hot, fetches the pattern for each digit, and optionally scrolls the message left across the display. It sits between the user-project control logic and the digit-select/segment pads.

---
 rtl/seg14_scroll_mux_if.sv | 30 +++
 rtl/seg14_scroll_mux.sv | 129 ++++++++++++
 tb/tb_seg14_scroll_mux.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg14_scroll_mux_if.sv
// Host-side bundle for seg14_scroll_mux: message-buffer writes, display mode and scan outputs.
// Latency: none (signal bundle only).
// Backpressure: none; writes are always accepted and the scan outputs free-run.
// Ports: wr_en/wr_addr/wr_data buffer write, msg_len/scroll_en display control,
//        sel/segm/frame_done digit scan outputs. master = host logic, slave = scanner.
interface seg14_scroll_mux_if #(
  parameter int NUM_DIGITS = 12,
  parameter int MSG_DEPTH  = 32
) ();
  localparam int AW = $clog2(MSG_DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [13:0]           wr_data;
  logic [AW:0]           msg_len;
  logic                  scroll_en;
  logic [NUM_DIGITS-1:0] sel;
  logic [13:0]           segm;
  logic                  frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, scroll_en,
    input  sel, segm, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, scroll_en,
    output sel, segm, frame_done
  );
endinterface

// File: rtl/seg14_scroll_mux.sv
// One-hot scanner for a bank of 14-segment digits fed from a writable message buffer, with optional left scroll.
// Latency: sel and segm are registered together on each scan tick (every SCAN_DIV clocks); frame_done rides with the last digit.
// Backpressure: none; buffer writes are always accepted and scanning never stalls.
// Ports: clk, rst (async, active-high); bus (slave modport) carries wr_en/wr_addr/wr_data, msg_len,
//        scroll_en in and sel/segm/frame_done out.
module seg14_scroll_mux #(
  parameter int NUM_DIGITS    = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int SCAN_DIV      = 1,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst,
  seg14_scroll_mux_if.slave  bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [AW:0]           DEPTH_C = (AW+1)'(MSG_DEPTH);
  localparam logic [DW-1:0]         LAST_D  = DW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         LAST_P  = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0]         LAST_F  = FW'(SCROLL_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  // Message buffer: no reset so contents survive a scanner reset.
  logic [13:0] mem [MSG_DEPTH];

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  logic [PW-1:0]         pre_q;
  logic [DW-1:0]         d_q;
  logic [AW-1:0]         off_q;
  logic [AW-1:0]         ptr_q;
  logic [FW-1:0]         fcnt_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [13:0]           segm_q;
  logic                  frame_done_q;

  logic          tick;
  logic          last_d;
  logic [AW:0]   len_eff;
  logic [AW-1:0] off_start;
  logic [AW-1:0] scan_idx;
  logic          idx_ok;
  logic [13:0]   pat;
  logic [AW:0]   idx_inc;
  logic [AW-1:0] ptr_nxt;
  logic [AW:0]   off_inc;
  logic [AW-1:0] off_adv;

  assign tick   = (pre_q == LAST_P);
  assign last_d = (d_q == LAST_D);

  always_comb begin
    len_eff   = (bus.msg_len > DEPTH_C) ? DEPTH_C : bus.msg_len;
    // An offset left stranded by a shorter message restarts from entry 0.
    off_start = ({1'b0, off_q} >= len_eff) ? '0 : off_q;
    scan_idx  = '0;
    idx_ok    = 1'b0;
    if (bus.scroll_en) begin
      // Running pointer replaces (offset + d) mod L: seeded at digit 0,
      // then stepped with wrap. The range guard keeps a mid-frame length
      // change from ever addressing past the message.
      if (d_q == '0) begin
        scan_idx = off_start;
      end else if ({1'b0, ptr_q} < len_eff) begin
        scan_idx = ptr_q;
      end
      idx_ok = (len_eff != '0);
    end else begin
      scan_idx = AW'(d_q);
      idx_ok   = ({1'b0, scan_idx} < len_eff);
    end
    pat     = idx_ok ? mem[scan_idx] : '0;
    idx_inc = {1'b0, scan_idx} + (AW+1)'(1);
    ptr_nxt = (idx_inc >= len_eff) ? '0 : idx_inc[AW-1:0];
    off_inc = {1'b0, off_q} + (AW+1)'(1);
    off_adv = (off_inc >= len_eff) ? '0 : off_inc[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      d_q          <= '0;
      off_q        <= '0;
      ptr_q        <= '0;
      fcnt_q       <= '0;
      sel_q        <= '0;
      segm_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= tick && last_d;

      if (tick) begin
        pre_q  <= '0;
        sel_q  <= SEL_ONE << d_q;
        segm_q <= pat;
        d_q    <= last_d ? '0 : d_q + DW'(1);
        ptr_q  <= ptr_nxt;
      end else begin
        pre_q <= pre_q + PW'(1);
      end

      // Offset only moves at frame boundaries so a frame is never torn.
      if (!bus.scroll_en) begin
        off_q  <= '0;
        fcnt_q <= '0;
      end else if (tick && (d_q == '0)) begin
        off_q <= off_start;
      end else if (tick && last_d) begin
        if (fcnt_q == LAST_F) begin
          fcnt_q <= '0;
          off_q  <= off_adv;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end
    end
  end

  assign bus.sel        = sel_q;
  assign bus.segm       = segm_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg14_scroll_mux.sv
module tb_seg14_scroll_mux;
  localparam int ND = 12;
  localparam int MD = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  always #5 clk = ~clk;

  seg14_scroll_mux_if #(.NUM_DIGITS(ND), .MSG_DEPTH(MD)) ifa ();
  seg14_scroll_mux_if #(.NUM_DIGITS(ND), .MSG_DEPTH(MD)) ifb ();

  seg14_scroll_mux #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .SCAN_DIV(1), .SCROLL_FRAMES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  seg14_scroll_mux #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .SCAN_DIV(4), .SCROLL_FRAMES(64)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [13:0] mbuf [MD];

  // Reference: what digit d shows for a given length, mode and frame offset.
  function automatic logic [13:0] model_pat(int d, int len, bit scroll, int off);
    int l;
    l = (len > MD) ? MD : len;
    if (l == 0) return 14'h0;
    if (!scroll) return (d < l) ? mbuf[d] : 14'h0;
    return mbuf[(off + d) % l];
  endfunction

  function automatic logic [ND-1:0] onehot(int d);
    logic [ND-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0]  r;
    logic [4:0]  lo;
    logic [13:0] v;
    rst = 1'b1; rst_b = 1'b1;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.msg_len = 6'd12; ifa.scroll_en = 1'b0;
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.msg_len = 6'd12; ifb.scroll_en = 1'b0;
    repeat (2) step();
    for (int i = 0; i < MD; i++) begin
      r  = 9'($urandom_range(0, 511));
      lo = 5'(i);
      v  = (i == 0) ? 14'b11001111000000 : {r, lo};
      mbuf[i] = v;
      ifa.wr_en = 1'b1; ifa.wr_addr = AW'(i); ifa.wr_data = v;
      ifb.wr_en = 1'b1; ifb.wr_addr = AW'(i); ifb.wr_data = v;
      step();
    end
    ifa.wr_en = 1'b0; ifb.wr_en = 1'b0;
    step();
    n_checks++; if (ifa.sel !== '0) begin n_fail++; $display("FAIL reset a.sel got %h exp 0", ifa.sel); end
    n_checks++; if (ifa.segm !== '0) begin n_fail++; $display("FAIL reset a.segm got %h exp 0", ifa.segm); end
    n_checks++; if (ifa.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset a.frame_done got %b exp 0", ifa.frame_done); end
    n_checks++; if (ifb.sel !== '0) begin n_fail++; $display("FAIL reset b.sel got %h exp 0", ifb.sel); end
    n_checks++; if (ifb.segm !== '0) begin n_fail++; $display("FAIL reset b.segm got %h exp 0", ifb.segm); end
    n_checks++; if (ifb.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset b.frame_done got %b exp 0", ifb.frame_done); end
  endtask

  task automatic test_static();
    int d;
    rst = 1'b0;
    for (int e = 1; e <= 2 * ND; e++) begin
      step();
      d = (e - 1) % ND;
      n_checks++; if (ifa.sel !== onehot(d)) begin n_fail++; $display("FAIL static sel edge %0d got %h exp %h", e, ifa.sel, onehot(d)); end
      n_checks++; if (ifa.segm !== model_pat(d, 12, 1'b0, 0)) begin n_fail++; $display("FAIL static segm edge %0d got %b exp %b", e, ifa.segm, model_pat(d, 12, 1'b0, 0)); end
      n_checks++; if (ifa.frame_done !== (d == ND - 1)) begin n_fail++; $display("FAIL static frame_done edge %0d got %b exp %b", e, ifa.frame_done, (d == ND - 1)); end
    end
  endtask

  task automatic test_write_collision();
    int d;
    logic [13:0] newv;
    newv = mbuf[3] ^ 14'h3FFF;
    for (int e = 0; e < 2 * ND; e++) begin
      d = e % ND;
      if (e == 3) begin
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = newv;
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd3; ifb.wr_data = newv;
      end
      step();
      ifa.wr_en = 1'b0; ifb.wr_en = 1'b0;
      n_checks++; if (ifa.sel !== onehot(d)) begin n_fail++; $display("FAIL collision sel step %0d got %h exp %h", e, ifa.sel, onehot(d)); end
      n_checks++; if (ifa.segm !== model_pat(d, 12, 1'b0, 0)) begin n_fail++; $display("FAIL collision segm step %0d got %b exp %b", e, ifa.segm, model_pat(d, 12, 1'b0, 0)); end
      if (e == 3) mbuf[3] = newv;
    end
  endtask

  task automatic test_short_blank();
    ifa.msg_len = 6'd3;
    for (int d = 0; d < ND; d++) begin
      step();
      n_checks++; if (ifa.sel !== onehot(d)) begin n_fail++; $display("FAIL short sel d=%0d got %h exp %h", d, ifa.sel, onehot(d)); end
      n_checks++; if (ifa.segm !== model_pat(d, 3, 1'b0, 0)) begin n_fail++; $display("FAIL short segm d=%0d got %b exp %b", d, ifa.segm, model_pat(d, 3, 1'b0, 0)); end
    end
    ifa.msg_len = 6'd0;
    for (int d = 0; d < ND; d++) begin
      step();
      n_checks++; if (ifa.sel !== onehot(d)) begin n_fail++; $display("FAIL blank sel d=%0d got %h exp %h", d, ifa.sel, onehot(d)); end
      n_checks++; if (ifa.segm !== 14'h0) begin n_fail++; $display("FAIL blank segm d=%0d got %b exp 0", d, ifa.segm); end
    end
  endtask

  task automatic test_scroll();
    int off;
    ifa.msg_len = 6'd14;
    ifa.scroll_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      off = (f / 2) % 14;
      for (int d = 0; d < ND; d++) begin
        step();
        n_checks++; if (ifa.sel !== onehot(d)) begin n_fail++; $display("FAIL scroll sel f=%0d d=%0d got %h exp %h", f, d, ifa.sel, onehot(d)); end
        n_checks++; if (ifa.segm !== model_pat(d, 14, 1'b1, off)) begin n_fail++; $display("FAIL scroll segm f=%0d d=%0d got %b exp %b", f, d, ifa.segm, model_pat(d, 14, 1'b1, off)); end
        n_checks++; if (ifa.frame_done !== (d == ND - 1)) begin n_fail++; $display("FAIL scroll frame_done f=%0d d=%0d got %b", f, d, ifa.frame_done); end
      end
    end
  endtask

  task automatic test_clamp_shrink();
    int off;
    int fc;
    int len;
    ifa.scroll_en = 1'b0;
    ifa.msg_len = 6'd40;
    for (int d = 0; d < ND; d++) begin
      step();
      n_checks++; if (ifa.segm !== model_pat(d, 40, 1'b0, 0)) begin n_fail++; $display("FAIL clamp static segm d=%0d got %b exp %b", d, ifa.segm, model_pat(d, 40, 1'b0, 0)); end
    end
    ifa.scroll_en = 1'b1;
    off = 0; fc = 0; len = 40;
    for (int f = 0; f < 25; f++) begin
      if (f == 21) begin
        len = 4;
        ifa.msg_len = 6'd4;
      end
      if (off >= ((len > MD) ? MD : len)) off = 0;
      for (int d = 0; d < ND; d++) begin
        step();
        n_checks++; if (ifa.segm !== model_pat(d, len, 1'b1, off)) begin n_fail++; $display("FAIL clamp scroll segm f=%0d d=%0d got %b exp %b", f, d, ifa.segm, model_pat(d, len, 1'b1, off)); end
      end
      fc++;
      if (fc == 2) begin
        fc = 0;
        off = (off + 1) % ((len > MD) ? MD : len);
      end
    end
  endtask

  task automatic test_async_reset();
    ifa.scroll_en = 1'b0;
    ifa.msg_len = 6'd12;
    repeat (6) step();
    n_checks++; if (ifa.sel !== onehot(5)) begin n_fail++; $display("FAIL areset pre sel got %h exp %h", ifa.sel, onehot(5)); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ifa.sel !== '0) begin n_fail++; $display("FAIL areset sel got %h exp 0", ifa.sel); end
    n_checks++; if (ifa.segm !== '0) begin n_fail++; $display("FAIL areset segm got %h exp 0", ifa.segm); end
    n_checks++; if (ifa.frame_done !== 1'b0) begin n_fail++; $display("FAIL areset frame_done got %b exp 0", ifa.frame_done); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (ifa.sel !== onehot(0)) begin n_fail++; $display("FAIL areset restart sel got %h exp %h", ifa.sel, onehot(0)); end
    n_checks++; if (ifa.segm !== mbuf[0]) begin n_fail++; $display("FAIL areset restart segm got %b exp %b", ifa.segm, mbuf[0]); end
  endtask

  task automatic test_prescaler();
    int t;
    int d;
    int pulses;
    logic [ND-1:0] es;
    logic [13:0]   eg;
    logic          ef;
    ifb.msg_len = 6'd12;
    ifb.scroll_en = 1'b0;
    step();
    rst_b = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 100; e++) begin
      step();
      t = e / 4;
      if (t == 0) begin
        es = '0; eg = 14'h0; ef = 1'b0;
      end else begin
        d  = (t - 1) % ND;
        es = onehot(d);
        eg = model_pat(d, 12, 1'b0, 0);
        ef = (e % 4 == 0) && (d == ND - 1);
      end
      if (ifb.frame_done === 1'b1) pulses++;
      n_checks++; if (ifb.sel !== es) begin n_fail++; $display("FAIL prescale sel clk %0d got %h exp %h", e, ifb.sel, es); end
      n_checks++; if (ifb.segm !== eg) begin n_fail++; $display("FAIL prescale segm clk %0d got %b exp %b", e, ifb.segm, eg); end
      n_checks++; if (ifb.frame_done !== ef) begin n_fail++; $display("FAIL prescale frame_done clk %0d got %b exp %b", e, ifb.frame_done, ef); end
    end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL prescale pulse_count got %0d exp 2", pulses); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_write_collision();
    test_short_blank();
    test_scroll();
    test_clamp_shrink();
    test_async_reset();
    test_prescaler();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
